// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//  Shared sizing constants and helpers for the lane FIFO (fifo_threshold) and
//  its storage array (fifo_mem).
//
//  Contents:
//   FIFO_DATA_WIDTH  default width of one stored word
//   FIFO_ADDR_WIDTH  default log2 of the FIFO depth
//   DEPTH            number of entries (2**FIFO_ADDR_WIDTH)
//   CNT_WIDTH        occupancy counter width; one bit wider than the pointers
//                    so that both 0 and DEPTH can be represented
//   THR_WIDTH        width of the controller's threshold buses
//   thr_ext()        zero-extends a threshold to the counter width so that
//                    threshold comparisons are plain unsigned compares
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 6;
    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int DEPTH           = 2 ** FIFO_ADDR_WIDTH;
    localparam int CNT_WIDTH       = FIFO_ADDR_WIDTH + 1;
    localparam int THR_WIDTH       = 3;

    // The threshold bus is narrower than the counter, so it must be padded
    // with zeros (never sign-extended) before it is compared with count.
    function automatic logic [CNT_WIDTH-1:0] thr_ext(input logic [THR_WIDTH-1:0] thr);
        return {{(CNT_WIDTH - THR_WIDTH){1'b0}}, thr};
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
//  DEPTH x DATA_WIDTH register array with one write port and one registered
//  read port. The array itself is not reset; only the read register is.
//
//  Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset (clears rd_data only)
//   wr_en    in   write wr_data into entry wr_addr at the next edge
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   capture entry rd_addr into rd_data at the next edge
//   rd_addr  in   read address
//   rd_data  out  registered read data, held while rd_en is low
// ---------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Next array contents: everything holds except the addressed entry on a
    // write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // The read register samples the current array contents, not mem_d, so a
    // simultaneous write to the same entry returns the old word
    // (read-before-write). That is what a push+pop on a full FIFO relies on.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage array: deliberately no reset so it can map onto plain
    // registers or distributed RAM.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read register: cleared by reset so data_out starts at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : fifo_mem

// File: rtl/fifo_threshold.sv
// ---------------------------------------------------------------------------
// fifo_threshold
//  Synchronous single-clock FIFO for one lane of the buffer bank in front of
//  the control state machine. Besides full/empty it offers programmable
//  almost_full / almost_empty flags so the producer can throttle and the
//  consumer can schedule pops, plus sticky overflow/underflow error bits.
//
//  Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset, overrides everything
//   push           in   write data_in this cycle
//   data_in        in   write data
//   pop            in   read the head entry this cycle
//   data_out       out  registered read data (held between pops)
//   valid_out      out  one-cycle pulse: data_out holds a freshly popped word
//   sup_threshold  in   almost_full threshold in entries
//   inf_threshold  in   almost_empty threshold in entries
//   full           out  count == DEPTH
//   empty          out  count == 0
//   almost_full    out  count >= sup_threshold
//   almost_empty   out  count <= inf_threshold
//   count          out  current occupancy, 0..DEPTH
//   overflow       out  sticky: a push was refused because the FIFO was full
//   underflow      out  sticky: a pop was refused because the FIFO was empty
// ---------------------------------------------------------------------------
module fifo_threshold
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic [THR_WIDTH-1:0]  sup_threshold,
    input  logic [THR_WIDTH-1:0]  inf_threshold,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int LOCAL_DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W       = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic                  valid_q,     valid_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  push_ok;
    logic                  pop_ok;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [CNT_W-1:0]      sup_ext;
    logic [CNT_W-1:0]      inf_ext;

    // Status flags are pure decodes of the registered count, so there is no
    // combinational path from push/pop to any flag. The thresholds are used
    // live, so a threshold change shows up on the flags in the same cycle.
    always_comb begin
        sup_ext      = CNT_W'(thr_ext(sup_threshold));
        inf_ext      = CNT_W'(thr_ext(inf_threshold));
        full         = (count_q == CNT_W'(LOCAL_DEPTH));
        empty        = (count_q == '0);
        almost_full  = (count_q >= sup_ext);
        almost_empty = (count_q <= inf_ext);
    end

    // Acceptance rules. A push on a full FIFO is still accepted when it is
    // paired with a pop, because the pop frees the slot in the same edge.
    // A pop on an empty FIFO is never accepted, even alongside a push: the
    // word being pushed is not yet readable, so there is no write-through.
    always_comb begin
        push_ok   = push & (~full | pop);
        pop_ok    = pop & ~empty;
        mem_wr_en = push_ok & ~reset;
        mem_rd_en = pop_ok & ~reset;
    end

    // Next-state for pointers, occupancy, the valid pulse and the sticky
    // error bits. Pointers are exactly ADDR_WIDTH bits, so they wrap from
    // DEPTH-1 back to 0 on their own.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            valid_d  = 1'b1;
        end

        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

        if (push & ~push_ok) begin
            overflow_d = 1'b1;
        end
        if (pop & ~pop_ok) begin
            underflow_d = 1'b1;
        end
    end

    // Control registers. Reset wins over every other input and discards all
    // stored entries by returning the pointers and count to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage with a registered read port: the head word lands in data_out
    // at the same edge that accepts the pop.
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (mem_rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    assign valid_out = valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : fifo_threshold

// File: tb/tb_fifo_threshold.sv
// ---------------------------------------------------------------------------
// tb_fifo_threshold
//  Self-checking bench for fifo_threshold. A queue-based reference model
//  tracks the FIFO contents, the last popped word and the sticky errors;
//  all flags are derived from the queue size and the threshold values.
// ---------------------------------------------------------------------------
module tb_fifo_threshold;

    logic       clk;
    logic       reset;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic [2:0] sup_threshold;
    logic [2:0] inf_threshold;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checksTotal;
    int checksPassed;

    // Reference model state
    int modelQ[$];
    int expData;
    bit expValid;
    bit expOverflow;
    bit expUnderflow;

    fifo_threshold dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .data_in       (data_in),
        .pop           (pop),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .sup_threshold (sup_threshold),
        .inf_threshold (inf_threshold),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and reports tag/observed/expected on failure
    task automatic chk(input string tag, input int observed, input int expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Drive one cycle of inputs, advance one clock edge, then step the model
    // with exactly the inputs the DUT sampled at that edge.
    task automatic applyStimulus(input bit rst, input bit doPush, input int din, input bit doPop);
        bit isFull;
        bit isEmpty;
        bit popAccepted;
        bit pushAccepted;
        reset   = rst;
        push    = doPush;
        data_in = 6'(din);
        pop     = doPop;
        @(posedge clk);
        #1;
        if (rst) begin
            modelQ.delete();
            expData      = 0;
            expValid     = 0;
            expOverflow  = 0;
            expUnderflow = 0;
        end else begin
            isFull       = (modelQ.size() == 8);
            isEmpty      = (modelQ.size() == 0);
            popAccepted  = doPop && !isEmpty;
            pushAccepted = doPush && (!isFull || doPop);
            expValid     = popAccepted;
            if (popAccepted) expData = modelQ.pop_front();
            if (doPush && !pushAccepted) expOverflow = 1;
            if (doPop && !popAccepted) expUnderflow = 1;
            if (pushAccepted) modelQ.push_back(din & 6'h3F);
        end
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    // Compare every output against the model
    task automatic checkOutput(input string tag);
        int n;
        n = modelQ.size();
        chk({tag, ".count"},        int'(count),        n);
        chk({tag, ".empty"},        int'(empty),        int'(n == 0));
        chk({tag, ".full"},         int'(full),         int'(n == 8));
        chk({tag, ".almost_full"},  int'(almost_full),  int'(n >= int'(sup_threshold)));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(n <= int'(inf_threshold)));
        chk({tag, ".valid_out"},    int'(valid_out),    int'(expValid));
        chk({tag, ".data_out"},     int'(data_out),     expData);
        chk({tag, ".overflow"},     int'(overflow),     int'(expOverflow));
        chk({tag, ".underflow"},    int'(underflow),    int'(expUnderflow));
    endtask

    initial begin
        checksTotal   = 0;
        checksPassed  = 0;
        reset         = 1'b1;
        push          = 1'b0;
        pop           = 1'b0;
        data_in       = '0;
        sup_threshold = 3'd6;
        inf_threshold = 3'd1;

        // T1: two reset cycles with push held high
        applyStimulus(1, 1, 5, 0);
        applyStimulus(1, 1, 5, 0);
        checkOutput("T1");
        chk("T1.count_zero", int'(count), 0);

        // T2: fill 0x01..0x08, then drain
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1, i, 0);
            checkOutput("T2.fill");
        end
        chk("T2.full_at_8", int'(full), 1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("T2.drain");
            chk("T2.order", int'(data_out), i);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("T2.idle");

        // T3: overflow on a lone push while full
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 16 + i, 0);
        applyStimulus(0, 1, 'h3F, 0);
        checkOutput("T3.ovf");
        chk("T3.ovf_set", int'(overflow), 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("T3.drain");
        end

        // T4: push+pop on empty is an underflow, the push still lands
        applyStimulus(0, 1, 'h2A, 1);
        checkOutput("T4.unf");
        chk("T4.count_one", int'(count), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("T4.pop");
        chk("T4.data", int'(data_out), 'h2A);

        // T5: push+pop at full, then 20 concurrent cycles around the wrap
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 32 + i, 0);
        applyStimulus(0, 1, 'h15, 1);
        checkOutput("T5.fullpp");
        chk("T5.oldest", int'(data_out), 32);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, int'($urandom_range(0, 63)), 1);
            checkOutput("T5.wrap");
        end

        // Live threshold extremes: sup=0 forces almost_full, inf=7 at full
        sup_threshold = 3'd0;
        inf_threshold = 3'd7;
        #1;
        checkOutput("THR.extreme_full");
        applyStimulus(0, 0, 0, 1);
        checkOutput("THR.extreme_7");

        // T6: reset with five entries, then only post-reset words come out
        sup_threshold = 3'd6;
        inf_threshold = 3'd1;
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 40 + i, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("T6.reset");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 50 + i, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("T6.pop");
        end

        // Randomized phase with random thresholds and occasional reset
        for (int i = 0; i < 300; i++) begin
            sup_threshold = 3'($urandom_range(0, 7));
            inf_threshold = 3'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 49) == 0),
                          1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 63)),
                          1'($urandom_range(0, 1)));
            checkOutput("RND");
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule : tb_fifo_threshold
